// File: rtl/ot_receiver_nway.sv
// rtl/ot_receiver_nway.sv - receiver side of a 1-out-of-NUM_MSG oblivious transfer over a byte link
// Only x_sel and m'_sel are kept; the other sender words stream past unstored.

module ot_receiver_nway #(
  parameter int WORD_BYTES  = 4,
  parameter int NUM_MSG     = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [$clog2(NUM_MSG)-1:0]  sel,
  input  logic                        rx_valid,
  output logic                        rx_ready,
  input  logic [7:0]                  rx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic [7:0]                  tx_data,
  output logic                        rnd_req,
  input  logic                        rnd_valid,
  input  logic [8*WORD_BYTES-1:0]     rnd_data,
  output logic                        eng_start,
  output logic [8*WORD_BYTES-1:0]     eng_base,
  output logic [8*WORD_BYTES-1:0]     eng_exp,
  output logic [8*WORD_BYTES-1:0]     eng_mod,
  input  logic                        eng_done,
  input  logic [8*WORD_BYTES-1:0]     eng_res,
  output logic [8*WORD_BYTES-1:0]     res,
  output logic                        res_valid,
  input  logic                        res_ack,
  output logic                        err,
  input  logic                        err_clr
);

  localparam int W     = 8 * WORD_BYTES;
  localparam int SEL_W = $clog2(NUM_MSG);
  localparam int BP_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int WI_W  = $clog2(NUM_MSG + 3);
  localparam int TO_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [BP_W-1:0]  BP_LAST   = BP_W'(WORD_BYTES - 1);
  localparam logic [WI_W-1:0]  KEY_LAST  = WI_W'(NUM_MSG + 1);
  localparam logic [WI_W-1:0]  MSG_LAST  = WI_W'(NUM_MSG - 1);
  localparam logic [SEL_W:0]   NUM_MSG_L = (SEL_W + 1)'(NUM_MSG);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_RX_KEY = 4'd1;
  localparam logic [3:0] S_RAND   = 4'd2;
  localparam logic [3:0] S_MODEXP = 4'd3;
  localparam logic [3:0] S_ADD    = 4'd4;
  localparam logic [3:0] S_TX_V   = 4'd5;
  localparam logic [3:0] S_RX_MSG = 4'd6;
  localparam logic [3:0] S_UNPACK = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;
  localparam logic [3:0] S_ERR    = 4'd9;

  logic [3:0]       state;
  logic [SEL_W-1:0] sel_reg;
  logic [BP_W-1:0]  byte_pos;
  logic [WI_W-1:0]  word_idx;
  logic [TO_W-1:0]  idle_cnt;
  logic [W-1:0]     n_reg, e_reg, x_reg, k_reg, r_reg, v_reg, m_reg, res_reg;

  logic             bp_last;
  logic [BP_W-1:0]  bp_next;
  logic [WI_W-1:0]  wi_next;
  logic [WI_W-1:0]  x_word;
  logic             to_hit;
  logic [W:0]       sum_w;
  logic [W-1:0]     v_next;

  assign bp_last = (byte_pos == BP_LAST);
  assign bp_next = bp_last ? '0 : byte_pos + 1'b1;
  assign wi_next = bp_last ? word_idx + 1'b1 : word_idx;
  assign x_word  = WI_W'(sel_reg) + WI_W'(2);
  assign to_hit  = (TIMEOUT_CYC > 0) && (idle_cnt == TO_LAST);

  // Single conditional subtraction: s < 2N is assumed, as x_sel and r are residues mod N.
  assign sum_w = {1'b0, x_reg} + {1'b0, r_reg};
  always_comb begin
    v_next = sum_w[W-1:0];
    if (sum_w >= {1'b0, n_reg}) v_next = W'(sum_w - {1'b0, n_reg});
  end

  assign rx_ready  = (state == S_IDLE) || (state == S_RX_KEY) || (state == S_RX_MSG);
  assign tx_valid  = (state == S_TX_V);
  assign tx_data   = tx_valid ? v_reg[8*byte_pos +: 8] : 8'd0;
  assign rnd_req   = (state == S_RAND);
  assign eng_base  = k_reg;
  assign eng_exp   = e_reg;
  assign eng_mod   = n_reg;
  assign res       = (state == S_DONE) ? res_reg : '0;
  assign res_valid = (state == S_DONE);
  assign err       = (state == S_ERR);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      sel_reg   <= '0;
      byte_pos  <= '0;
      word_idx  <= '0;
      idle_cnt  <= '0;
      n_reg     <= '0;
      e_reg     <= '0;
      x_reg     <= '0;
      k_reg     <= '0;
      r_reg     <= '0;
      v_reg     <= '0;
      m_reg     <= '0;
      res_reg   <= '0;
      eng_start <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      case (state)
        S_IDLE: if (rx_valid) begin
          if ({1'b0, sel} >= NUM_MSG_L) begin
            state <= S_ERR;
          end else begin
            sel_reg    <= sel;
            n_reg[7:0] <= rx_data;
            byte_pos   <= bp_next;
            word_idx   <= wi_next;
            idle_cnt   <= '0;
            state      <= S_RX_KEY;
          end
        end
        S_RX_KEY: if (rx_valid) begin
          idle_cnt <= '0;
          if (word_idx == '0)              n_reg[8*byte_pos +: 8] <= rx_data;
          else if (word_idx == WI_W'(1))   e_reg[8*byte_pos +: 8] <= rx_data;
          else if (word_idx == x_word)     x_reg[8*byte_pos +: 8] <= rx_data;
          byte_pos <= bp_next;
          word_idx <= wi_next;
          if (bp_last && word_idx == KEY_LAST) begin
            word_idx <= '0;
            state    <= S_RAND;
          end
        end else if (to_hit) begin
          state <= S_ERR;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
        S_RAND: if (rnd_valid) begin
          k_reg     <= rnd_data;
          eng_start <= 1'b1;
          state     <= S_MODEXP;
        end
        S_MODEXP: if (eng_done) begin
          r_reg <= eng_res;
          state <= S_ADD;
        end
        S_ADD: begin
          v_reg <= v_next;
          state <= S_TX_V;
        end
        S_TX_V: if (tx_ready) begin
          byte_pos <= bp_next;
          if (bp_last) begin
            idle_cnt <= '0;
            word_idx <= '0;
            state    <= S_RX_MSG;
          end
        end
        S_RX_MSG: if (rx_valid) begin
          idle_cnt <= '0;
          if (word_idx == WI_W'(sel_reg)) m_reg[8*byte_pos +: 8] <= rx_data;
          byte_pos <= bp_next;
          word_idx <= wi_next;
          if (bp_last && word_idx == MSG_LAST) begin
            word_idx <= '0;
            state    <= S_UNPACK;
          end
        end else if (to_hit) begin
          state <= S_ERR;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
        S_UNPACK: begin
          res_reg <= (m_reg >= k_reg) ? (m_reg - k_reg) : (m_reg - k_reg + n_reg);
          state   <= S_DONE;
        end
        S_DONE: if (res_ack) state <= S_IDLE;
        S_ERR: if (err_clr) begin
          byte_pos <= '0;
          word_idx <= '0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ot_receiver_nway.md
Name: ot_receiver_nway

Overview:
- Parametrised receiver side of a 1-out-of-NUM_MSG oblivious transfer over a byte-serial valid/ready link.
- Deserialises the sender's key and random values, and fetches the blinding value k from an external random source.
- Uses a shared external modular-exponentiation engine for k^e mod N, then returns the blinded value v.
- Unpacks the selected message, adds inter-byte timeout and error reporting, and re-arms after the result is acknowledged.

Parameters:
- WORD_BYTES, 4, bytes per operand; W = 8*WORD_BYTES.
- NUM_MSG, 2, number of sender messages (>=2); SEL_W = clog2(NUM_MSG).
- TIMEOUT_CYC, 1024, maximum idle cycles between accepted bytes in a receive phase; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- sel  in  SEL_W  choice index, latched on the first accepted byte
- rx_valid  in  1  inbound byte valid
- rx_ready  out  1  inbound byte accept
- rx_data  in  8  inbound byte
- tx_valid  out  1  outbound byte valid
- tx_ready  in  1  outbound byte accept
- tx_data  out  8  outbound byte
- rnd_req  out  1  request for a random value
- rnd_valid  in  1  random value valid (single-cycle)
- rnd_data  in  W  random value k
- eng_start  out  1  modexp start pulse
- eng_base  out  W  base (k)
- eng_exp  out  W  exponent (e)
- eng_mod  out  W  modulus (N)
- eng_done  in  1  modexp done (single-cycle)
- eng_res  in  W  modexp result
- res  out  W  unpacked message; 0 unless state is DONE
- res_valid  out  1  result available
- res_ack  in  1  result consumed
- err  out  1  protocol error, sticky
- err_clr  in  1  clear error

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low, on rstn. While rstn=0 the block is in IDLE with rx_ready=1 and tx_valid=0, tx_data=0, rnd_req=0, eng_start=0, res=0, res_valid=0, err=0; counters and operand registers are cleared. Reset mid-operation aborts immediately with no partial output.
- Byte order: all operands are little-endian (LSB byte first). An inbound byte transfers on rx_valid&&rx_ready; an outbound byte transfers on tx_valid&&tx_ready.
- IDLE: rx_ready=1. On the first accepted byte: latch sel, store the byte as N[7:0], go to RX_KEY.
  - If sel >= NUM_MSG: go to ERR instead.
- RX_KEY: rx_ready=1. Accept the rest of N, then e, then x_0..x_{NUM_MSG-1}; total (2+NUM_MSG)*WORD_BYTES bytes counted from IDLE.
  - After the last byte: rx_ready=0 the next cycle, go to RAND.
- RAND: rnd_req=1 until rnd_valid. Latch k=rnd_data, drop rnd_req, go to MODEXP.
- MODEXP: eng_start is pulsed exactly one cycle on entry, with eng_base=k, eng_exp=e, eng_mod=N held stable until eng_done. On eng_done, latch r=eng_res and go to ADD.
- ADD (1 cycle): s = x_sel + r computed at W+1 bits; v = (s >= N) ? s-N : s[W-1:0]. Go to TX_V.
- TX_V: tx_valid=1 with tx_data = v byte i, i = 0..WORD_BYTES-1.
  - tx_data must be held while tx_ready=0; advance only on a transfer.
  - Back-to-back transfers are allowed: one byte per cycle while tx_ready=1.
  - After the last transfer: tx_valid=0, go to RX_MSG.
- RX_MSG: rx_ready=1. Accept m'_0..m'_{NUM_MSG-1} (NUM_MSG*WORD_BYTES bytes), then go to UNPACK.
- UNPACK (1 cycle): res_w = (m'_sel >= k) ? m'_sel-k : m'_sel-k+N, computed modulo 2^W. Go to DONE.
- DONE: res=res_w, res_valid=1, rx_ready=0. On res_ack: res_valid=0, res=0, go to IDLE, rx_ready=1 the next cycle.
- Timeout: an idle counter runs in RX_KEY and RX_MSG and resets on each accepted byte.
  - When it reaches TIMEOUT_CYC (TIMEOUT_CYC>0), go to ERR.
  - The counter does not run in IDLE, RAND, MODEXP or TX_V.
- ERR: err=1, rx_ready=0, tx_valid=0, rnd_req=0. On err_clr: err=0, go to IDLE.
- Simultaneous events:
  - err_clr outside ERR is ignored.
  - res_ack outside DONE is ignored.
  - rnd_valid outside RAND and eng_done outside MODEXP are ignored.
  - rx_valid while rx_ready=0 is not consumed.
- Latency: from the last key byte to the first tx_valid = 2 cycles + random latency + engine latency + 1.

Test Plan:
- Setup: WORD_BYTES=4, NUM_MSG=2. Bench engine returns 1000 after checking base=5, exp=17, mod=3233; rnd returns 5.
- sel=1: N=3233, e=17, x0=100, x1=2500 -> tx bytes 0B 01 00 00 (v=267, one subtraction); m'0=7, m'1=2 -> res=3230 (borrow path), res_valid=1 until res_ack.
- sel=0, same keys -> tx bytes 4C 04 00 00 (v=1100); m'0=7 -> res=2. After res_ack a second full transfer succeeds with no reset.
- tx_ready toggling 1,0,0,1,... during TX_V -> tx_data held stable while stalled; exactly 4 transfers in order; rx_ready=0 throughout.
- rx_valid gap of TIMEOUT_CYC (set 16) cycles mid-RX_KEY -> err=1, rx_ready=0; err_clr -> IDLE, then a full sel=1 run gives res=3230.
- NUM_MSG=3 build, sel=3 on the first byte -> ERR immediately. rstn=0 asserted mid-TX_V -> tx_valid=0 and rx_ready=1 with no clock edge; no further tx bytes.
